// File: rtl/puck_mover.sv
// Puck animator: per frame tick, erase the 4x4 puck, step it with wall bounce, redraw it.
// Latency: first pixel 1 cycle after an accepted tick; 16 erase + 1 update + 16 draw; done 34 cycles after the tick.
// Backpressure: none; ticks and serves arriving while busy are dropped (counted in overrun when FRAME_OVERRUN_EN is defined).
//
// Ports: clock; resetn (synchronous, active HIGH despite the name); enable gates tick acceptance;
//   frame_tick starts a frame; serve reloads the serve position while idle;
//   x/y/colour/plot form the registered VGA pixel-write interface;
//   busy is high outside IDLE; done pulses for 1 cycle at the end of DRAW.
// Optional: define FRAME_OVERRUN_EN to add the 8-bit saturating overrun port
//   (count of frame ticks that arrived while busy).
module puck_mover #(
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter int          PUCK_SIZE   = 4,
    parameter int          X_INIT      = 78,
    parameter int          Y_INIT      = 58,
    parameter logic [2:0]  PUCK_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic       serve,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
`ifdef FRAME_OVERRUN_EN
    output logic [7:0] overrun,
`endif
    output logic       done
);

    localparam logic [7:0] X_MAX = 8'(SCREEN_W - PUCK_SIZE);
    localparam logic [6:0] Y_MAX = 7'(SCREEN_H - PUCK_SIZE);
    localparam logic [7:0] X_RST = 8'(X_INIT);
    localparam logic [6:0] Y_RST = 7'(Y_INIT);

    typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_px, w_px_nxt;
    logic [6:0] r_py, w_py_nxt;
    logic       r_dir_x, w_dir_x_nxt;   // 1 = right (+x)
    logic       r_dir_y, w_dir_y_nxt;   // 1 = down  (+y)
    logic [7:0] r_x, w_x_nxt;
    logic [6:0] r_y, w_y_nxt;
    logic [2:0] r_colour, w_colour_nxt;
    logic       r_plot, w_plot_nxt;
    logic       r_done, w_done_nxt;

    always_ff @(posedge clock) begin
        if (resetn) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_px     <= X_RST;
            r_py     <= Y_RST;
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b1;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_px     <= w_px_nxt;
            r_py     <= w_py_nxt;
            r_dir_x  <= w_dir_x_nxt;
            r_dir_y  <= w_dir_y_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_colour <= w_colour_nxt;
            r_plot   <= w_plot_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_px_nxt     = r_px;
        w_py_nxt     = r_py;
        w_dir_x_nxt  = r_dir_x;
        w_dir_y_nxt  = r_dir_y;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_colour_nxt = r_colour;
        w_plot_nxt   = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                // serve has priority; a coincident tick is discarded
                if (serve) begin
                    w_px_nxt    = X_RST;
                    w_py_nxt    = Y_RST;
                    w_dir_x_nxt = 1'b1;
                    w_dir_y_nxt = 1'b1;
                end else if (frame_tick && enable) begin
                    w_state_nxt = ERASE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ERASE: begin
                if (r_cnt == 4'd15) w_state_nxt = UPDATE;
                else                w_cnt_nxt   = r_cnt + 4'd1;
            end
            UPDATE: begin
                // a wall hit reverses and steps away in the same frame
                if (r_dir_x && r_px == X_MAX) begin
                    w_dir_x_nxt = 1'b0;
                    w_px_nxt    = r_px - 8'd1;
                end else if (!r_dir_x && r_px == 8'd0) begin
                    w_dir_x_nxt = 1'b1;
                    w_px_nxt    = r_px + 8'd1;
                end else begin
                    w_px_nxt = r_dir_x ? r_px + 8'd1 : r_px - 8'd1;
                end
                if (r_dir_y && r_py == Y_MAX) begin
                    w_dir_y_nxt = 1'b0;
                    w_py_nxt    = r_py - 7'd1;
                end else if (!r_dir_y && r_py == 7'd0) begin
                    w_dir_y_nxt = 1'b1;
                    w_py_nxt    = r_py + 7'd1;
                end else begin
                    w_py_nxt = r_dir_y ? r_py + 7'd1 : r_py - 7'd1;
                end
                w_state_nxt = DRAW;
                w_cnt_nxt   = 4'd0;
            end
            DRAW: begin
                if (r_cnt == 4'd15) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Pixel registers are loaded with the pixel of the state being entered,
        // so the first erase pixel appears the cycle after the tick and the draw
        // pixels already use the stepped position.
        if (w_state_nxt == ERASE || w_state_nxt == DRAW) begin
            w_plot_nxt   = 1'b1;
            w_x_nxt      = w_px_nxt + {6'd0, w_cnt_nxt[1:0]};
            w_y_nxt      = w_py_nxt + {5'd0, w_cnt_nxt[3:2]};
            w_colour_nxt = (w_state_nxt == ERASE) ? BG_COLOUR : PUCK_COLOUR;
        end
    end

`ifdef FRAME_OVERRUN_EN
    logic [7:0] r_overrun;

    always_ff @(posedge clock) begin
        if (resetn)
            r_overrun <= 8'd0;
        else if (frame_tick && r_state != IDLE && r_overrun != 8'hFF)
            r_overrun <= r_overrun + 8'd1;
    end

    assign overrun = r_overrun;
`endif

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = (r_state != IDLE);
    assign done   = r_done;

endmodule

// File: tb/tb_puck_mover.sv
// Bench for puck_mover: expected pixel streams are queued when a frame is started
// and popped by a monitor whenever plot is seen.
// Covers reset values, latency, wall bounces, late ticks, serve, enable and mid-frame reset.
module tb_puck_mover;

    logic       clock = 1'b0;
    logic       resetn;
    logic       enable;
    logic       frame_tick;
    logic       serve;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
`ifdef FRAME_OVERRUN_EN
    logic [7:0] overrun;
`endif

    int total = 0;
    int bad   = 0;

    logic [17:0] exp_q[$];   // {x, y, colour}

    int mpx, mpy;
    bit mdx, mdy;

    puck_mover dut (
        .clock      (clock),
        .resetn     (resetn),
        .enable     (enable),
        .frame_tick (frame_tick),
        .serve      (serve),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
`ifdef FRAME_OVERRUN_EN
        .overrun    (overrun),
`endif
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Every plotted pixel must match the head of the expected queue.
    always @(negedge clock) begin
        if (plot === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_plot", {31'd0, plot}, 32'd0);
            end else begin
                check("pixel", {14'd0, x, y, colour}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic model_reset();
        mpx = 78; mpy = 58; mdx = 1'b1; mdy = 1'b1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < 16; i++)
            exp_q.push_back({8'(mpx + (i & 3)), 7'(mpy + (i >> 2)), 3'd0});
        if (mdx && mpx == 156)     begin mdx = 1'b0; mpx = mpx - 1; end
        else if (!mdx && mpx == 0) begin mdx = 1'b1; mpx = mpx + 1; end
        else                       mpx = mdx ? mpx + 1 : mpx - 1;
        if (mdy && mpy == 116)     begin mdy = 1'b0; mpy = mpy - 1; end
        else if (!mdy && mpy == 0) begin mdy = 1'b1; mpy = mpy + 1; end
        else                       mpy = mdy ? mpy + 1 : mpy - 1;
        for (int i = 0; i < 16; i++)
            exp_q.push_back({8'(mpx + (i & 3)), 7'(mpy + (i >> 2)), 3'd7});
    endtask

    // One frame: tick, optional late ticks from cycle 5, optional reset at cycle abort_at.
    task automatic frame(input int late, input int abort_at);
        int n;
        push_frame();
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        n = 1;
        check("first_plot", {31'd0, plot}, 32'd1);
        check("busy_on", {31'd0, busy}, 32'd1);
        while (!done && n < 60) begin
            frame_tick = (late > 0 && n >= 5 && n < 5 + late);
            if (n == abort_at) resetn = 1'b1;
            @(negedge clock);
            n++;
            if (abort_at > 0 && n == abort_at + 1) begin
                resetn = 1'b0;
                frame_tick = 1'b0;
                check("abort_plot", {31'd0, plot}, 32'd0);
                check("abort_busy", {31'd0, busy}, 32'd0);
                exp_q.delete();
                model_reset();
                return;
            end
        end
        frame_tick = 1'b0;
        check("done_latency", n, 32'd34);
        check("done_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1; enable = 1'b1; frame_tick = 1'b0; serve = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check("rst_x", {24'd0, x}, 32'd0);
        check("rst_y", {25'd0, y}, 32'd0);
        check("rst_colour", {29'd0, colour}, 32'd0);
        check("rst_plot", {31'd0, plot}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
`ifdef FRAME_OVERRUN_EN
        check("rst_overrun", {24'd0, overrun}, 32'd0);
`endif
        resetn = 1'b0;
        @(negedge clock);

        // Basic frame from the serve position
        frame(0, 0);

        // One late tick at T+5 is dropped
        frame(1, 0);
`ifdef FRAME_OVERRUN_EN
        check("overrun_one", {24'd0, overrun}, 32'd1);
`endif

        // Many frames: bottom wall at ~58, right wall at ~78, top ~174, left ~234.
        // The first 11 carry 28 late ticks each, saturating the overrun counter.
        for (int f = 0; f < 238; f++)
            frame((f < 11) ? 28 : 0, 0);
`ifdef FRAME_OVERRUN_EN
        check("overrun_sat", {24'd0, overrun}, 32'd255);
`endif
        check("model_left_wall", mdx, 1'b1);
        check("model_top_wall", mdy, 1'b1);

        // serve with a coincident tick: reload, no frame
        @(negedge clock);
        serve = 1'b1; frame_tick = 1'b1;
        @(negedge clock);
        serve = 1'b0; frame_tick = 1'b0;
        model_reset();
        check("serve_busy", {31'd0, busy}, 32'd0);
        check("serve_plot", {31'd0, plot}, 32'd0);
        repeat (3) @(negedge clock);
        check("serve_idle", {31'd0, busy}, 32'd0);

        // enable low: tick ignored
        enable = 1'b0; frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        @(negedge clock);
        check("disabled_busy", {31'd0, busy}, 32'd0);
        check("disabled_plot", {31'd0, plot}, 32'd0);
        enable = 1'b1;

        // frame after serve starts from 78,58
        frame(0, 0);
        frame(0, 0);

        // reset at DRAW cycle 10 (cycle 28 after the tick), then a normal frame
        frame(0, 28);
        repeat (2) @(negedge clock);
        check("post_abort_busy", {31'd0, busy}, 32'd0);
        frame(0, 0);
        frame(0, 0);

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
